// File: rtl/jtframe_vidout_pkg.sv
// rtl/jtframe_vidout_pkg.sv - shared state encoding and colour width scaling for the video output selector
package jtframe_vidout_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_MUTE    = 2'd2
   } state_t;

   // Output bit k (from the MSB) takes input bit (k mod iw) from the MSB: this
   // replicates MSBs when widening and keeps the top bits when narrowing.
   function automatic logic [31:0] scale_color(input logic [31:0] v, input int iw, input int ow);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) begin
         if (k < ow) r[5'(ow - 1 - k)] = v[5'(iw - 1 - (k % iw))];
      end
      return r;
   endfunction

endpackage

// File: rtl/jtframe_edge_det.sv
// rtl/jtframe_edge_det.sv - one-cycle rise/fall pulses from the previous-cycle sample
module jtframe_edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_q, din_d;

   always_comb begin
      din_d = din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) din_q <= RST_VAL;
      else        din_q <= din_d;
   end

   assign rise = din & ~din_q;
   assign fall = ~din & din_q;

endmodule

// File: rtl/jtframe_vidout_sel.sv
// rtl/jtframe_vidout_sel.sv - registered native/scan-doubled video selector with frame-aligned muted switching; JTFRAME_SCANLINES_EN adds scanline dimming
import jtframe_vidout_pkg::*;

module jtframe_vidout_sel #(
   parameter int COLORW      = 4,
   parameter int SCANW       = 6,
   parameter int OUTW        = 6,
   parameter int MUTE_FRAMES = 2,
   parameter int TOW         = 20
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic [COLORW-1:0] game_r,
   input  logic [COLORW-1:0] game_g,
   input  logic [COLORW-1:0] game_b,
   input  logic              hs,
   input  logic              vs,
   input  logic [SCANW-1:0]  scan2x_r,
   input  logic [SCANW-1:0]  scan2x_g,
   input  logic [SCANW-1:0]  scan2x_b,
   input  logic              scan2x_hs,
   input  logic              scan2x_vs,
   input  logic              scan2x_req,
   input  logic              scan_dim,
   output logic [OUTW-1:0]   VIDEO_R,
   output logic [OUTW-1:0]   VIDEO_G,
   output logic [OUTW-1:0]   VIDEO_B,
   output logic              VIDEO_HS,
   output logic              VIDEO_VS,
   output logic              scan2x_enb,
   output logic              switching
);

   state_t          state_q, state_d;
   logic            enb_q, enb_d, sw_q, sw_d;
   logic [3:0]      mute_q, mute_d;
   logic [TOW-1:0]  to_q, to_d;
   logic [OUTW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic            hs_q, hs_d, vs_q, vs_d;

   logic            vs_rise, svs_fall, act_edge, to_full;
   logic [1:0]      unused_edge;
   logic [OUTW-1:0] nat_r, nat_g, nat_b, sc_r, sc_g, sc_b, scn_r, scn_g, scn_b;

   jtframe_edge_det #(.RST_VAL(1'b0)) u_vs (
      .clk(clk_sys), .rst_n(rst_n), .din(vs), .rise(vs_rise), .fall(unused_edge[0])
   );

   jtframe_edge_det #(.RST_VAL(1'b1)) u_svs (
      .clk(clk_sys), .rst_n(rst_n), .din(scan2x_vs), .rise(unused_edge[1]), .fall(svs_fall)
   );

   assign nat_r = OUTW'(scale_color(32'(game_r), COLORW, OUTW));
   assign nat_g = OUTW'(scale_color(32'(game_g), COLORW, OUTW));
   assign nat_b = OUTW'(scale_color(32'(game_b), COLORW, OUTW));
   assign sc_r  = OUTW'(scale_color(32'(scan2x_r), SCANW, OUTW));
   assign sc_g  = OUTW'(scale_color(32'(scan2x_g), SCANW, OUTW));
   assign sc_b  = OUTW'(scale_color(32'(scan2x_b), SCANW, OUTW));

`ifdef JTFRAME_SCANLINES_EN
   logic par_q, par_d, shs_fall, unused_shs_rise, dim;

   jtframe_edge_det #(.RST_VAL(1'b1)) u_shs (
      .clk(clk_sys), .rst_n(rst_n), .din(scan2x_hs), .rise(unused_shs_rise), .fall(shs_fall)
   );

   // Line parity restarts at every frame so line 0 is always bright.
   always_comb begin
      par_d = par_q;
      if (svs_fall)      par_d = 1'b0;
      else if (shs_fall) par_d = ~par_q;
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end

   assign dim   = scan_dim & par_q;
   assign scn_r = dim ? (sc_r >> 1) : sc_r;
   assign scn_g = dim ? (sc_g >> 1) : sc_g;
   assign scn_b = dim ? (sc_b >> 1) : sc_b;
`else
   logic unused_dim;
   assign unused_dim = scan_dim;
   assign scn_r = sc_r;
   assign scn_g = sc_g;
   assign scn_b = sc_b;
`endif

   // The frame edge always follows whichever source currently drives the pins.
   assign act_edge = enb_q ? vs_rise : svs_fall;
   assign to_full  = &to_q;

   always_comb begin
      state_d = state_q;
      enb_d   = enb_q;
      sw_d    = sw_q;
      mute_d  = mute_q;
      to_d    = to_q;
      case (state_q)
         ST_RUN: begin
            if (scan2x_req == enb_q) begin
               state_d = ST_WAIT_VS;
               to_d    = '0;
               sw_d    = 1'b1;
            end
         end
         ST_WAIT_VS: begin
            to_d = to_q + TOW'(1);
            if (scan2x_req != enb_q) begin
               state_d = ST_RUN;
               sw_d    = 1'b0;
            end else if (act_edge || to_full) begin
               enb_d   = ~enb_q;
               mute_d  = 4'(MUTE_FRAMES);
               to_d    = '0;
               state_d = ST_MUTE;
            end
         end
         ST_MUTE: begin
            to_d = to_q + TOW'(1);
            if (to_full) begin
               state_d = ST_RUN;
               sw_d    = 1'b0;
               mute_d  = '0;
            end else if (act_edge) begin
               mute_d = mute_q - 4'd1;
               if (mute_q == 4'd1) begin
                  state_d = ST_RUN;
                  sw_d    = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            sw_d    = 1'b0;
         end
      endcase
   end

   always_comb begin
      if (enb_q) begin
         r_d  = nat_r;
         g_d  = nat_g;
         b_d  = nat_b;
         hs_d = ~((~hs) ^ (~vs));
         vs_d = 1'b1;
      end else begin
         r_d  = scn_r;
         g_d  = scn_g;
         b_d  = scn_b;
         hs_d = scan2x_hs;
         vs_d = scan2x_vs;
      end
      if (state_q == ST_MUTE) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         enb_q   <= 1'b1;
         sw_q    <= 1'b0;
         mute_q  <= '0;
         to_q    <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         enb_q   <= enb_d;
         sw_q    <= sw_d;
         mute_q  <= mute_d;
         to_q    <= to_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign VIDEO_R    = r_q;
   assign VIDEO_G    = g_q;
   assign VIDEO_B    = b_q;
   assign VIDEO_HS   = hs_q;
   assign VIDEO_VS   = vs_q;
   assign scan2x_enb = enb_q;
   assign switching  = sw_q;

endmodule

// File: tb/tb_jtframe_vidout_sel.sv
// tb/tb_jtframe_vidout_sel.sv - self-checking bench for jtframe_vidout_sel
module tb_jtframe_vidout_sel;

   localparam int MUTE_N = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] game_r = '0, game_g = '0, game_b = '0;
   logic       hs = 1'b0, vs = 1'b0;
   logic [5:0] s_r = '0, s_g = '0, s_b = '0;
   logic       s_hs = 1'b1, s_vs = 1'b1, req = 1'b0, dim = 1'b0;

   logic [5:0] a_r, a_g, a_b, b_r, b_g, b_b;
   logic       a_hs, a_vs, a_enb, a_sw, b_hs, b_vs, b_enb, b_sw;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   jtframe_vidout_sel dut (
      .clk_sys(clk), .rst_n(rst_n),
      .game_r(game_r), .game_g(game_g), .game_b(game_b), .hs(hs), .vs(vs),
      .scan2x_r(s_r), .scan2x_g(s_g), .scan2x_b(s_b), .scan2x_hs(s_hs), .scan2x_vs(s_vs),
      .scan2x_req(req), .scan_dim(dim),
      .VIDEO_R(a_r), .VIDEO_G(a_g), .VIDEO_B(a_b), .VIDEO_HS(a_hs), .VIDEO_VS(a_vs),
      .scan2x_enb(a_enb), .switching(a_sw)
   );

   jtframe_vidout_sel #(.TOW(4)) dut_to (
      .clk_sys(clk), .rst_n(rst_n),
      .game_r(game_r), .game_g(game_g), .game_b(game_b), .hs(hs), .vs(vs),
      .scan2x_r(s_r), .scan2x_g(s_g), .scan2x_b(s_b), .scan2x_hs(s_hs), .scan2x_vs(s_vs),
      .scan2x_req(req), .scan_dim(dim),
      .VIDEO_R(b_r), .VIDEO_G(b_g), .VIDEO_B(b_b), .VIDEO_HS(b_hs), .VIDEO_VS(b_vs),
      .scan2x_enb(b_enb), .switching(b_sw)
   );

   // Behavioural reference: scan = which source is live, phase 0 idle / 1 pending / 2 muted.
   typedef struct {
      int         scan, phase, left, waited;
      logic       pvs, psvs, pshs, par;
      logic [5:0] r, g, b;
      logic       ohs, ovs, enb, sw;
   } mdl_t;

   typedef struct {
      logic [3:0] gr, gg, gb;
      logic       h, v;
      logic [5:0] sr, sg, sb;
      logic       sh, sv;
      logic [19:0] exp;
   } vec_t;

   mdl_t m0, m1;

   function automatic logic [5:0] rep4(input logic [3:0] c);
      int x;
      x = int'(c);
      return 6'((x << 2) | (x >> 2));
   endfunction

   function automatic mdl_t step(input mdl_t m, input int tow);
      mdl_t n;
      logic vr, sf, hf, frame;
      int   limit;
      n = m;
      if (!rst_n) begin
         n.scan = 0; n.phase = 0; n.left = 0; n.waited = 0;
         n.pvs = 1'b0; n.psvs = 1'b1; n.pshs = 1'b1; n.par = 1'b0;
         n.r = '0; n.g = '0; n.b = '0; n.ohs = 1'b1; n.ovs = 1'b1; n.enb = 1'b1; n.sw = 1'b0;
         return n;
      end
      vr    = vs & ~m.pvs;
      sf    = ~s_vs & m.psvs;
      hf    = ~s_hs & m.pshs;
      frame = (m.scan != 0) ? sf : vr;
      if (m.scan != 0) begin
         n.r = s_r; n.g = s_g; n.b = s_b;
`ifdef JTFRAME_SCANLINES_EN
         if (dim && m.par) begin
            n.r = s_r / 2; n.g = s_g / 2; n.b = s_b / 2;
         end
`endif
         n.ohs = s_hs; n.ovs = s_vs;
      end else begin
         n.r = rep4(game_r); n.g = rep4(game_g); n.b = rep4(game_b);
         n.ohs = (hs == vs); n.ovs = 1'b1;
      end
      if (m.phase == 2) begin
         n.r = '0; n.g = '0; n.b = '0;
      end
      limit = (1 << tow) - 1;
      case (m.phase)
         0: if (int'(req) != m.scan) begin n.phase = 1; n.waited = 0; end
         1: begin
            if (int'(req) == m.scan) n.phase = 0;
            else if (frame || m.waited == limit) begin
               n.scan = 1 - m.scan; n.phase = 2; n.left = MUTE_N; n.waited = 0;
            end else n.waited = m.waited + 1;
         end
         default: begin
            if (m.waited == limit) n.phase = 0;
            else begin
               n.waited = m.waited + 1;
               if (frame) begin
                  n.left = m.left - 1;
                  if (n.left == 0) n.phase = 0;
               end
            end
         end
      endcase
      if (sf) n.par = 1'b0;
      else if (hf) n.par = ~m.par;
      n.pvs = vs; n.psvs = s_vs; n.pshs = s_hs;
      n.enb = (n.scan == 0);
      n.sw  = (n.phase != 0);
      return n;
   endfunction

   function automatic logic [22:0] pk(input mdl_t m);
      return {m.r, m.g, m.b, m.ohs, m.ovs, m.enb, m.sw};
   endfunction

   task automatic tick();
      @(posedge clk);
      m0 = step(m0, 20);
      m1 = step(m1, 4);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   vec_t nat_tab[4];
   vec_t scan_tab[4];
   int   bad;
   int   n;

   initial begin
      nat_tab[0] = '{4'hF, 4'h8, 4'h0, 1'b0, 1'b0, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, {6'h3F, 6'h22, 6'h00, 1'b1, 1'b1}};
      nat_tab[1] = '{4'h5, 4'hA, 4'h1, 1'b1, 1'b0, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, {6'h15, 6'h2A, 6'h04, 1'b0, 1'b1}};
      nat_tab[2] = '{4'h0, 4'h3, 4'hC, 1'b0, 1'b1, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, {6'h00, 6'h0C, 6'h33, 1'b0, 1'b1}};
      nat_tab[3] = '{4'h7, 4'hE, 4'h9, 1'b1, 1'b1, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, {6'h1D, 6'h3B, 6'h26, 1'b1, 1'b1}};
      scan_tab[0] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'h3E, 6'h01, 6'h2A, 1'b1, 1'b1, {6'h3E, 6'h01, 6'h2A, 1'b1, 1'b1}};
      scan_tab[1] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'h00, 6'h3F, 6'h15, 1'b0, 1'b1, {6'h00, 6'h3F, 6'h15, 1'b0, 1'b1}};
      scan_tab[2] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'h11, 6'h22, 6'h33, 1'b1, 1'b0, {6'h11, 6'h22, 6'h33, 1'b1, 1'b0}};
      scan_tab[3] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, {6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0}};

      // Reset values, then first native cycle
      game_r = 4'hF;
      tick();
      tick();
      chk("rst_outputs", {a_r, a_g, a_b, a_hs, a_vs, a_enb, a_sw}, {18'h0, 1'b1, 1'b1, 1'b1, 1'b0});
      rst_n = 1'b1;
      tick();
      chk("native_first", {a_r, a_hs, a_vs, a_enb}, {6'h3F, 1'b1, 1'b1, 1'b1});

      foreach (nat_tab[i]) begin
         game_r = nat_tab[i].gr; game_g = nat_tab[i].gg; game_b = nat_tab[i].gb;
         hs = nat_tab[i].h; vs = nat_tab[i].v;
         tick();
         chk($sformatf("native_vec%0d", i), {a_r, a_g, a_b, a_hs, a_vs}, nat_tab[i].exp);
      end

      // Native -> scan switch aligned to vs rise, then two muted scan frames
      vs = 1'b0; hs = 1'b0; game_r = 4'hF; s_r = 6'h2A; s_vs = 1'b1; s_hs = 1'b1;
      tick();
      tick();
      req = 1'b1;
      tick();
      chk("sw_req", a_sw, 1);
      chk("enb_hold", a_enb, 1);
      bad = 0;
      repeat (5) begin tick(); if (a_r != 6'h3F || a_enb != 1'b1) bad++; end
      chk("native_persist", bad, 0);
      vs = 1'b1;
      tick();
      chk("enb_switch", a_enb, 0);
      bad = 0;
      repeat (4) begin tick(); if (a_r != 6'h00) bad++; end
      s_vs = 1'b0; tick(); if (a_r != 6'h00) bad++; s_vs = 1'b1;
      repeat (4) begin tick(); if (a_r != 6'h00) bad++; end
      chk("mute_frames", bad, 0);
      chk("sw_muting", a_sw, 1);
      s_vs = 1'b0;
      tick();
      chk("mute_last", a_r, 6'h00);
      chk("sw_clear", a_sw, 0);
      s_vs = 1'b1;
      tick();
      chk("scan_after_mute", a_r, 6'h2A);

      foreach (scan_tab[i]) begin
         s_r = scan_tab[i].sr; s_g = scan_tab[i].sg; s_b = scan_tab[i].sb;
         s_hs = scan_tab[i].sh; s_vs = scan_tab[i].sv;
         tick();
         chk($sformatf("scan_vec%0d", i), {a_r, a_g, a_b, a_hs, a_vs}, scan_tab[i].exp);
      end

`ifdef JTFRAME_SCANLINES_EN
      dim = 1'b1; s_g = 6'h3E; s_hs = 1'b1; s_vs = 1'b1;
      tick();
      s_vs = 1'b0; tick(); s_vs = 1'b1; tick();
      chk("line_even", a_g, 6'h3E);
      s_hs = 1'b0; tick(); tick();
      chk("line_odd", a_g, 6'h1F);
      s_hs = 1'b1; tick(); s_hs = 1'b0; tick(); tick();
      chk("line_even2", a_g, 6'h3E);
      s_hs = 1'b1; tick(); s_hs = 1'b0; tick(); tick();
      chk("line_odd2", a_g, 6'h1F);
      s_vs = 1'b0; tick(); s_vs = 1'b1; tick();
      chk("parity_vs_clear", a_g, 6'h3E);
      dim = 1'b0;
`endif

      // Short request pulse must not change mode or mute
      req = 1'b0; vs = 1'b0; s_vs = 1'b1; s_hs = 1'b1; game_r = 4'hF; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req = 1'b1;
      bad = 0;
      repeat (10) begin tick(); if (a_r != 6'h3F) bad++; end
      chk("pulse_pending", a_sw, 1);
      req = 1'b0;
      tick();
      if (a_r != 6'h3F) bad++;
      chk("pulse_sw_clear", a_sw, 0);
      chk("pulse_enb", a_enb, 1);
      repeat (3) begin tick(); if (a_r != 6'h3F) bad++; end
      chk("pulse_never_muted", bad, 0);

      // Forced switch with no vs edge (TOW = 4 instance)
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; req = 1'b1;
      tick();
      chk("to_sw", b_sw, 1);
      n = 0;
      while (b_enb && n < 40) begin tick(); n++; end
      chk("timeout_cycles", n, 16);
      chk("no_timeout_default", a_enb, 1);

      // Reset while muting aborts the switch
      tick();
      chk("in_mute", {b_sw, b_enb}, {1'b1, 1'b0});
      rst_n = 1'b0;
      tick();
      chk("rst_mute", {b_r, b_g, b_b, b_hs, b_vs, b_enb, b_sw}, {18'h0, 1'b1, 1'b1, 1'b1, 1'b0});
      rst_n = 1'b1; req = 1'b0;
      tick();

      // Random traffic against the reference model, both instances
      rst_n = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4000; i++) begin
         rst_n  = ($urandom_range(0, 499) != 0);
         game_r = 4'($urandom); game_g = 4'($urandom); game_b = 4'($urandom);
         s_r = 6'($urandom); s_g = 6'($urandom); s_b = 6'($urandom);
         hs = 1'($urandom);
         if ($urandom_range(0, 19) == 0) vs = ~vs;
         if ($urandom_range(0, 7) == 0) s_vs = ~s_vs;
         if ($urandom_range(0, 2) == 0) s_hs = ~s_hs;
         if ($urandom_range(0, 59) == 0) req = ~req;
         dim = 1'($urandom);
         tick();
         chk("rand_dut", {a_r, a_g, a_b, a_hs, a_vs, a_enb, a_sw}, pk(m0));
         chk("rand_dut_to", {b_r, b_g, b_b, b_hs, b_vs, b_enb, b_sw}, pk(m1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtframe_vidout_sel.md
Name: jtframe_vidout_sel

Overview:
- Parametrised, registered video output selector for the board base modules.
- Chooses between the native 15 kHz game video and the scan-doubled VGA video, and scales both to the board DAC width.
- Generates composite sync in native mode.
- Switches mode glitch-free: only at a frame boundary, followed by a muted settling period. Sits between the scan doubler and the board video pins.

Parameters:
- COLORW, 4, native colour width per channel
- SCANW, 6, scan-doubler colour width per channel
- OUTW, 6, board DAC width per channel
- MUTE_FRAMES, 2, frames of black output after a mode switch (1..15)
- TOW, 20, timeout counter width; forced switch after 2^TOW cycles with no VS edge

Ports:
- clk_sys  in  1  system clock; all inputs are synchronous to it
- rst_n  in  1  reset, synchronous, active-low
- game_r/game_g/game_b  in  COLORW each  native colour
- hs, vs  in  1  native syncs, active-high
- scan2x_r/scan2x_g/scan2x_b  in  SCANW each  scan-doubled colour
- scan2x_hs, scan2x_vs  in  1  VGA syncs, active-low
- scan2x_req  in  1  requested mode: 1 = scan doubler, 0 = native
- scan_dim  in  1  scanline dimming request (used only with the optional feature)
- VIDEO_R/VIDEO_G/VIDEO_B  out  OUTW each  output colour
- VIDEO_HS, VIDEO_VS  out  1  output syncs
- scan2x_enb  out  1  active mode: 1 = native, 0 = scan doubler
- switching  out  1  high while a mode change is pending or muting

Behaviour:
- Reset (rst_n low at a clk_sys edge):
  - VIDEO_R/G/B = 0, VIDEO_HS = 1, VIDEO_VS = 1
  - scan2x_enb = 1, switching = 0
  - state RUN, mute and timeout counters cleared
- Latency: all outputs registered; 1 clk_sys cycle from input to output.
- Width scaling:
  - Native colour is expanded to OUTW by MSB bit replication, e.g. 4'hF -> 6'h3F, 4'h8 -> 6'h22.
  - Scan colour: if SCANW > OUTW, truncate LSBs; if SCANW < OUTW, replicate MSBs; if equal, pass through.
- Syncs:
  - Native: HSync = ~hs, VSync = ~vs; VIDEO_HS = ~(HSync ^ VSync) (composite sync); VIDEO_VS = 1.
  - Scan: VIDEO_HS = scan2x_hs, VIDEO_VS = scan2x_vs.
- Frame edge: "active VS edge" means the start of vsync of the currently active source: rising edge of vs in native mode, falling edge of scan2x_vs in scan mode. Detected from the previous-cycle sample.
- State machine:
  - RUN: colour passes through. If scan2x_req != ~scan2x_enb, go to WAIT_VS, clear the timeout counter, set switching = 1.
  - WAIT_VS: old mode keeps driving the outputs; timeout counter increments each cycle.
    - If scan2x_req returns to the active mode: back to RUN, switching = 0.
    - On an active VS edge, or when the timeout counter reaches all-ones: toggle scan2x_enb, load mute counter = MUTE_FRAMES, go to MUTE.
    - A VS edge and timeout in the same cycle count as one event.
  - MUTE: colour forced to 0; syncs come from the new mode. Each active VS edge of the new mode decrements the counter. At 0, go to RUN and clear switching. The timeout also applies here and forces RUN.
    - scan2x_req changes are ignored in MUTE and re-evaluated on the first RUN cycle.
- Reset asserted mid-switch aborts the switch: native mode, RUN.

Optional Feature:
- Macro: JTFRAME_SCANLINES_EN.
- With the macro:
  - A line parity bit toggles on each scan2x_hs falling edge and clears on each scan2x_vs falling edge.
  - In scan mode with scan_dim = 1 and parity = 1, each colour is output as (value >> 1) after width scaling.
  - Native mode is unaffected.
- Without the macro: scan_dim is ignored, no parity logic exists, and the scan path passes through unmodified.

Decomposition:
- Package jtframe_vidout_pkg: state encoding (RUN, WAIT_VS, MUTE) and a colour width-scaling function (replicate or truncate).
- Sub-module jtframe_edge_det: one-cycle rise/fall pulse generator, instanced for vs, scan2x_vs and scan2x_hs.

Test Plan:
- Reset with game_r = 4'hF, native mode -> cycle after release VIDEO_R = 6'h3F; scan2x_enb = 1; VIDEO_VS = 1; VIDEO_HS = ~(~hs ^ ~vs).
- scan2x_req 0 -> 1 mid-frame -> switching = 1; native video persists until the next vs rise; then scan2x_enb = 0.
  - VIDEO_R = 0 for exactly 2 scan2x_vs falls, then equals scan2x_r; switching = 0.
- scan2x_req pulses 1 for 10 cycles, then back to 0, before any vs edge -> no mode change; switching returns to 0; video never muted.
- vs held low, scan2x_req = 1, TOW = 4 -> forced switch after 16 cycles; scan2x_enb = 0.
- rst_n low during MUTE -> next cycle scan2x_enb = 1, switching = 0, outputs at reset values.
- JTFRAME_SCANLINES_EN, scan mode, scan_dim = 1, scan2x_g = 6'h3E -> even lines 6'h3E, odd lines 6'h1F; parity reset at each vsync.
